seg_scan_mux: RTL

Parametrised time-multiplexing driver for common-anode multi-digit 7-segment displays; successor to the fixed 4-digit BCD scan mux.
- Generalised to NUM_DIGITS digits, with per-digit decimal points and PWM brightness dimming.
- Double-buffered input: new values appear only at frame boundaries, so there is no tearing.
- Sits between the calculator datapath and the BCD-to-segment decoder.

---
 rtl/seg_scan_pkg.sv | 15 +
 rtl/scan_tick_gen.sv | 33 +++
 rtl/seg_scan_mux.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the seg_scan_mux multi-digit 7-segment scan driver.
package seg_scan_pkg;

  typedef logic [3:0] bcd_t;

  localparam int MAX_DIGITS = 8;

  // Anode select with every digit dark; narrower displays take the low bits.
  localparam logic [MAX_DIGITS-1:0] DIGIT_OFF = '1;

  function automatic int cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Refresh counter for the scan mux: emits a one-cycle tick at the end of every digit slot.
module scan_tick_gen
  import seg_scan_pkg::*;
#(
  parameter int unsigned REFRESH_OVERFLOW = 2**19-1
)(
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = cnt_width(REFRESH_OVERFLOW);
  localparam logic [CW-1:0] TERMINAL = CW'(REFRESH_OVERFLOW);

  logic [CW-1:0] count;

  // Held at zero while scanning is disabled so a resumed scan starts a full slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == TERMINAL) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = enable && (count == TERMINAL);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with double-buffered digits and PWM dimming.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shown).
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int          NUM_DIGITS       = 4,
  parameter int unsigned REFRESH_OVERFLOW = 2**19-1,
  parameter int          DIM_BITS         = 4
)(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [DIM_BITS-1:0]     brightness,
  output logic [3:0]              output_number,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_select,
  output logic                    frame_done
);

  localparam int SW = cnt_width(NUM_DIGITS - 1);
  localparam logic [SW-1:0] LAST_SEL = SW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF = DIGIT_OFF[NUM_DIGITS-1:0];

  logic                         tick;
  logic                         boundary;
  logic [SW-1:0]                sel;
  logic [DIM_BITS-1:0]          phase;
  bcd_t [NUM_DIGITS-1:0]        pend_digits;
  bcd_t [NUM_DIGITS-1:0]        act_digits;
  logic [NUM_DIGITS-1:0]        pend_dp;
  logic [NUM_DIGITS-1:0]        act_dp;
  logic                         pend_valid;
  logic [NUM_DIGITS-1:0]        sel_onecold;
  logic [NUM_DIGITS-1:0]        blank_mask;
  logic                         lit;

  scan_tick_gen #(
    .REFRESH_OVERFLOW(REFRESH_OVERFLOW)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .tick   (tick)
  );

  assign boundary = tick && (sel == LAST_SEL);

  // Digit index and PWM phase both restart from zero whenever scanning resumes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel   <= '0;
      phase <= '0;
    end else if (!enable) begin
      sel   <= '0;
      phase <= '0;
    end else begin
      phase <= phase + DIM_BITS'(1);
      if (tick) begin
        sel <= (sel == LAST_SEL) ? '0 : sel + SW'(1);
      end
    end
  end

  // Active digits only change at a frame boundary; a load landing on the boundary skips pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_valid  <= 1'b0;
      act_digits  <= '0;
      act_dp      <= '0;
    end else if (load && boundary) begin
      act_digits <= digits_in;
      act_dp     <= dp_in;
      pend_valid <= 1'b0;
    end else begin
      if (boundary && pend_valid) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
        pend_valid <= 1'b0;
      end
      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
        pend_valid  <= 1'b1;
      end
    end
  end

  always_comb begin
    sel_onecold = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel == SW'(k)) sel_onecold[k] = 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // Walk down from the most significant digit; blanking stops at the first visible content.
  always_comb begin
    upper_zero = 1'b1;
    blank_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero    = upper_zero && (act_digits[k] == 4'd0) && !act_dp[k];
      blank_mask[k] = upper_zero;
    end
  end
`else
  assign blank_mask = '0;
`endif

  assign lit = (phase < brightness) && ((blank_mask & ~sel_onecold) == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      output_number <= '0;
      dp_out        <= 1'b0;
      digit_select  <= ALL_OFF;
      frame_done    <= 1'b0;
    end else begin
      output_number <= act_digits[sel];
      dp_out        <= act_dp[sel];
      digit_select  <= (enable && lit) ? sel_onecold : ALL_OFF;
      frame_done    <= boundary;
    end
  end

endmodule
